// File: rtl/barcode_entry_buffer.sv
// Keypad barcode entry buffer: collects BCD digits with backspace/clear,
// validates requests, and hands a completed barcode downstream via valid/ready.
module barcode_entry_buffer #(
  parameter int NUM_DIGITS  = 4,
  parameter bit AUTO_COMMIT = 1'b0,
  localparam int CW = $clog2(NUM_DIGITS + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              digit_in,
  input  logic                    digit_strobe,
  input  logic                    backspace,
  input  logic                    clear,
  input  logic                    commit,
  output logic [4*NUM_DIGITS-1:0] barcode_out,
  output logic [NUM_DIGITS-1:0]   digit_valid_mask,
  output logic [CW-1:0]           num_digits_entered,
  output logic                    barcode_completed,
  output logic                    barcode_valid,
  input  logic                    barcode_ready,
  output logic                    error_pulse
);

  typedef enum logic {EDIT, HOLD} state_t;

  localparam logic [CW-1:0] FULL = CW'(NUM_DIGITS);
  localparam logic [CW-1:0] LAST = CW'(NUM_DIGITS - 1);

  state_t                  state, state_next;
  logic [4*NUM_DIGITS-1:0] digits, digits_next;
  logic [CW-1:0]           count, count_next;
  logic [NUM_DIGITS-1:0]   mask_q, mask_next;
  logic                    completed_q, completed_next;
  logic                    error_q, error_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= EDIT;
      digits      <= '0;
      count       <= '0;
      mask_q      <= '0;
      completed_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state       <= state_next;
      digits      <= digits_next;
      count       <= count_next;
      mask_q      <= mask_next;
      completed_q <= completed_next;
      error_q     <= error_next;
    end
  end

  // Only one request acts per cycle; lower-priority requests are dropped.
  always_comb begin
    state_next  = state;
    digits_next = digits;
    count_next  = count;
    error_next  = 1'b0;
    case (state)
      EDIT: begin
        if (clear) begin
          digits_next = '0;
          count_next  = '0;
        end else if (backspace) begin
          if (count == '0) begin
            error_next = 1'b1;
          end else begin
            digits_next = {4'd0, digits[4*NUM_DIGITS-1:4]};
            count_next  = count - CW'(1);
          end
        end else if (digit_strobe) begin
          if (count == FULL || digit_in > 4'd9) begin
            error_next = 1'b1;
          end else begin
            digits_next = {digits[4*NUM_DIGITS-5:0], digit_in};
            count_next  = count + CW'(1);
            if (AUTO_COMMIT && count == LAST) state_next = HOLD;
          end
        end else if (commit && !AUTO_COMMIT) begin
          if (count == FULL) state_next = HOLD;
          else               error_next = 1'b1;
        end
      end
      HOLD: begin
        // CLEAR and a completed transfer both empty the buffer.
        if (clear || barcode_ready) begin
          digits_next = '0;
          count_next  = '0;
          state_next  = EDIT;
        end else if (digit_strobe || backspace || (commit && !AUTO_COMMIT)) begin
          error_next = 1'b1;
        end
      end
      default: state_next = EDIT;
    endcase
  end

  always_comb begin
    mask_next = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      mask_next[i] = (CW'(i) < count_next);
    end
    completed_next = (count_next == FULL);
  end

  assign barcode_out        = digits;
  assign digit_valid_mask   = mask_q;
  assign num_digits_entered = count;
  assign barcode_completed  = completed_q;
  assign barcode_valid      = (state == HOLD);
  assign error_pulse        = error_q;

endmodule

// File: tb/tb_barcode_entry_buffer.sv
// Bench for barcode_entry_buffer: a 4-digit manual-commit and a 6-digit
// auto-commit instance share stimulus and are checked against a digit-list model.
module tb_barcode_entry_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [3:0] digit_in = 4'd0;
  logic       digit_strobe = 1'b0, backspace = 1'b0, clear = 1'b0;
  logic       commit = 1'b0, barcode_ready = 1'b0;

  logic [15:0] barcode4;
  logic [3:0]  mask4;
  logic [2:0]  count4;
  logic        completed4, valid4, err4;

  logic [23:0] barcode6;
  logic [5:0]  mask6;
  logic [2:0]  count6;
  logic        completed6, valid6, err6;

  barcode_entry_buffer #(.NUM_DIGITS(4), .AUTO_COMMIT(1'b0)) dut4 (
    .clk(clk), .reset(reset), .digit_in(digit_in), .digit_strobe(digit_strobe),
    .backspace(backspace), .clear(clear), .commit(commit),
    .barcode_out(barcode4), .digit_valid_mask(mask4), .num_digits_entered(count4),
    .barcode_completed(completed4), .barcode_valid(valid4),
    .barcode_ready(barcode_ready), .error_pulse(err4)
  );

  barcode_entry_buffer #(.NUM_DIGITS(6), .AUTO_COMMIT(1'b1)) dut6 (
    .clk(clk), .reset(reset), .digit_in(digit_in), .digit_strobe(digit_strobe),
    .backspace(backspace), .clear(clear), .commit(commit),
    .barcode_out(barcode6), .digit_valid_mask(mask6), .num_digits_entered(count6),
    .barcode_completed(completed6), .barcode_valid(valid6),
    .barcode_ready(barcode_ready), .error_pulse(err6)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  // Model: m_d[k][i] is digit i (0 = newest) of instance k; 0 = 4-digit, 1 = 6-digit.
  int m_d[2][8];
  int m_cnt[2];
  bit m_hold[2];
  bit m_err[2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) m_d[k][i] = 0;
      m_cnt[k] = 0; m_hold[k] = 0; m_err[k] = 0;
    end
  end

  function automatic void emptyModel(int k);
    for (int i = 0; i < 8; i++) m_d[k][i] = 0;
    m_cnt[k] = 0;
  endfunction

  function automatic void modelStep(int k, int n, bit ac);
    m_err[k] = 0;
    if (reset) begin
      emptyModel(k);
      m_hold[k] = 0;
    end else if (!m_hold[k]) begin
      if (clear) begin
        emptyModel(k);
      end else if (backspace) begin
        if (m_cnt[k] == 0) m_err[k] = 1;
        else begin
          for (int i = 0; i < n - 1; i++) m_d[k][i] = m_d[k][i+1];
          m_d[k][n-1] = 0;
          m_cnt[k]--;
        end
      end else if (digit_strobe) begin
        if (m_cnt[k] == n || int'(digit_in) > 9) m_err[k] = 1;
        else begin
          for (int i = n - 1; i > 0; i--) m_d[k][i] = m_d[k][i-1];
          m_d[k][0] = int'(digit_in);
          m_cnt[k]++;
          if (ac && m_cnt[k] == n) m_hold[k] = 1;
        end
      end else if (commit && !ac) begin
        if (m_cnt[k] == n) m_hold[k] = 1;
        else m_err[k] = 1;
      end
    end else begin
      if (clear || barcode_ready) begin
        emptyModel(k);
        m_hold[k] = 0;
      end else if (digit_strobe || backspace || (commit && !ac)) begin
        m_err[k] = 1;
      end
    end
  endfunction

  function automatic logic [31:0] packDigits(int k, int n);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < n; i++) v = v | (32'(m_d[k][i]) << (4 * i));
    return v;
  endfunction

  always @(posedge clk) begin
    modelStep(0, 4, 1'b0);
    modelStep(1, 6, 1'b1);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      checkOutput("d4_barcode", 32'(barcode4), packDigits(0, 4));
      checkOutput("d4_mask", 32'(mask4), (32'd1 << m_cnt[0]) - 32'd1);
      checkOutput("d4_count", 32'(count4), 32'(m_cnt[0]));
      checkOutput("d4_completed", 32'(completed4), 32'(m_cnt[0] == 4));
      checkOutput("d4_valid", 32'(valid4), 32'(m_hold[0]));
      checkOutput("d4_error", 32'(err4), 32'(m_err[0]));
      checkOutput("d6_barcode", 32'(barcode6), packDigits(1, 6));
      checkOutput("d6_mask", 32'(mask6), (32'd1 << m_cnt[1]) - 32'd1);
      checkOutput("d6_count", 32'(count6), 32'(m_cnt[1]));
      checkOutput("d6_completed", 32'(completed6), 32'(m_cnt[1] == 6));
      checkOutput("d6_valid", 32'(valid6), 32'(m_hold[1]));
      checkOutput("d6_error", 32'(err6), 32'(m_err[1]));
    end
  end

  task automatic applyStimulus(input logic r, input logic [3:0] din, input logic stb,
                               input logic bs, input logic clr, input logic cmt,
                               input logic rdy);
    @(negedge clk);
    reset = r; digit_in = din; digit_strobe = stb; backspace = bs;
    clear = clr; commit = cmt; barcode_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic pressDigit(input logic [3:0] d);
    applyStimulus(1'b0, d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp_on = 1'b1;
    checkOutput("reset_count", 32'(count4), 32'd0);
    checkOutput("reset_valid", 32'(valid4), 32'd0);
    checkOutput("reset_barcode", 32'(barcode4), 32'd0);
    idle();

    // Manual commit and delayed ready.
    pressDigit(4'd1); pressDigit(4'd2); pressDigit(4'd3); pressDigit(4'd4);
    checkOutput("fill_barcode", 32'(barcode4), 32'h1234);
    checkOutput("fill_count", 32'(count4), 32'd4);
    checkOutput("fill_mask", 32'(mask4), 32'hF);
    checkOutput("fill_completed", 32'(completed4), 32'd1);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("commit_valid", 32'(valid4), 32'd1);
    idle(); idle();
    checkOutput("hold_barcode", 32'(barcode4), 32'h1234);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("xfer_valid", 32'(valid4), 32'd0);
    checkOutput("xfer_count", 32'(count4), 32'd0);

    // Entry right after the transfer, then backspace to underflow.
    pressDigit(4'd5); pressDigit(4'd6);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("bs_barcode", 32'(barcode4), 32'h0005);
    checkOutput("bs_count", 32'(count4), 32'd1);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("bs_empty_error", 32'(err4), 32'd1);
    checkOutput("bs_empty_count", 32'(count4), 32'd0);
    idle();
    checkOutput("error_one_cycle", 32'(err4), 32'd0);

    // Invalid digit and overfill.
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    pressDigit(4'hA);
    checkOutput("bad_digit_error", 32'(err4), 32'd1);
    checkOutput("bad_digit_count", 32'(count4), 32'd0);
    pressDigit(4'd7); pressDigit(4'd3); pressDigit(4'd0); pressDigit(4'd9);
    pressDigit(4'd5);
    checkOutput("overfill_error", 32'(err4), 32'd1);
    checkOutput("overfill_barcode", 32'(barcode4), 32'h7309);

    // Clear wins over strobe; early commit rejected.
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    pressDigit(4'd2); pressDigit(4'd3);
    applyStimulus(1'b0, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("clr_strobe_count", 32'(count4), 32'd0);
    checkOutput("clr_strobe_error", 32'(err4), 32'd0);
    pressDigit(4'd1); pressDigit(4'd2); pressDigit(4'd3);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("early_commit_error", 32'(err4), 32'd1);
    checkOutput("early_commit_valid", 32'(valid4), 32'd0);

    // Auto-commit on the 6-digit instance.
    applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pressDigit(4'd9); pressDigit(4'd8); pressDigit(4'd7);
    pressDigit(4'd6); pressDigit(4'd5); pressDigit(4'd4);
    checkOutput("auto_valid", 32'(valid6), 32'd1);
    checkOutput("auto_barcode", 32'(barcode6), 32'h987654);
    pressDigit(4'd3);
    checkOutput("auto_hold_error", 32'(err6), 32'd1);
    checkOutput("auto_hold_barcode", 32'(barcode6), 32'h987654);

    // Reset during HOLD, then a late ready.
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("d4_hold_valid", 32'(valid4), 32'd1);
    applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_hold_valid4", 32'(valid4), 32'd0);
    checkOutput("rst_hold_valid6", 32'(valid6), 32'd0);
    checkOutput("rst_hold_count6", 32'(count6), 32'd0);
    checkOutput("rst_hold_mask6", 32'(mask6), 32'd0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("late_ready_count", 32'(count6), 32'd0);
    checkOutput("late_ready_valid", 32'(valid6), 32'd0);
    checkOutput("late_ready_error", 32'(err6), 32'd0);
    idle(); idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/barcode_entry_buffer.md
# barcode_entry_buffer

Parametrised successor to the 4-digit barcode shift register. It holds up to NUM_DIGITS BCD digits entered from the keypad decoder, with backspace, clear, input validation and error flagging. A completed barcode is handed to the product-lookup block over a valid/ready handshake. It sits between the keypad decoder and the price lookup/display logic of the sale terminal.

## Interface
- NUM_DIGITS, 4: barcode length in digits; legal range 2..8.
- AUTO_COMMIT, 0: 1 = commit automatically when the last digit is accepted; 0 = wait for COMMIT.
- CW (derived, not overridable): $clog2(NUM_DIGITS+1), width of the digit count.
- CLK  in  1  system clock (CLOCK_50); all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- DIGIT_IN  in  4  BCD digit; sampled only when DIGIT_STROBE=1.
- DIGIT_STROBE  in  1  one-cycle request to append DIGIT_IN.
- BACKSPACE  in  1  one-cycle request to remove the most recent digit.
- CLEAR  in  1  one-cycle request to empty the buffer and abort any pending hand-off.
- COMMIT  in  1  one-cycle request to hand off the barcode (ignored when AUTO_COMMIT=1).
- BARCODE_OUT  out  4*NUM_DIGITS  digits; [3:0] is digit 0, the most recently entered.
- DIGIT_VALID_MASK  out  NUM_DIGITS  bit i=1 when digit i holds an entered value (display blanking).
- NUM_DIGITS_ENTERED  out  CW  count of entered digits, 0..NUM_DIGITS.
- BARCODE_COMPLETED  out  1  high while count==NUM_DIGITS.
- BARCODE_VALID  out  1  hand-off valid; BARCODE_OUT is stable while high.
- BARCODE_READY  in  1  downstream accepts the barcode.
- ERROR_PULSE  out  1  one-cycle flag for a rejected request.

## Operation
- States:
  - EDIT: buffer editable.
  - HOLD: buffer frozen, BARCODE_VALID=1.
- Reset: state EDIT, all digits 0, count 0, mask 0, VALID 0, ERROR_PULSE 0, COMPLETED 0.
- EDIT, one request per cycle. Priority CLEAR > BACKSPACE > DIGIT_STROBE > COMMIT; lower-priority requests in the same cycle are dropped silently (no error).
  - CLEAR: all digits 0, count 0.
  - BACKSPACE with count>0: digit i takes digit i+1; the top digit becomes 0; count decrements.
  - BACKSPACE with count=0: ERROR_PULSE, no change.
  - DIGIT_STROBE with count<NUM_DIGITS and DIGIT_IN<=9: digit i+1 takes digit i; digit 0 takes DIGIT_IN; count increments.
  - DIGIT_STROBE when full, or with DIGIT_IN>9: ERROR_PULSE, no change.
  - COMMIT (AUTO_COMMIT=0) with count==NUM_DIGITS: go to HOLD.
  - COMMIT with count<NUM_DIGITS: ERROR_PULSE, stay in EDIT.
  - AUTO_COMMIT=1: accepting the NUM_DIGITS-th digit moves to HOLD on the same edge.
- HOLD:
  - VALID & READY: transfer. Clear the buffer and return to EDIT.
  - CLEAR: clear the buffer and return to EDIT. Counts as no error even if READY is high in the same cycle.
  - DIGIT_STROBE, BACKSPACE or COMMIT without CLEAR: ERROR_PULSE, no change. VALID stays held until READY.
- DIGIT_VALID_MASK bit i = (i < count).
- BARCODE_COMPLETED = (count == NUM_DIGITS); it is also high throughout HOLD.
- Count arithmetic saturates by rejection; count never wraps.

## Timing
- All outputs are registered and update on the edge after the sampled request; effect latency is 1 cycle.
- ERROR_PULSE is high for exactly the one cycle after the offending request.
- BARCODE_VALID rises 1 cycle after the accepted COMMIT, or after the final digit when AUTO_COMMIT=1.
- Handshake:
  - VALID never drops without a transfer or CLEAR.
  - READY may be high before VALID; the transfer occurs on the first edge where both are high.
  - VALID, count and digits are 0 on the following cycle.
  - A DIGIT_STROBE in the cycle after the transfer is accepted normally.
- RESET overrides everything, including mid-HOLD. VALID drops on the next edge and no transfer is counted.

## Test plan
- NUM_DIGITS=4, AUTO_COMMIT=0: strobe 1,2,3,4 -> BARCODE_OUT=16'h1234, count=4, mask=4'b1111, COMPLETED=1; COMMIT -> VALID=1 next cycle; READY after 3 cycles -> digits held stable until the transfer, then VALID=0, count=0.
- Enter 5,6, BACKSPACE -> BARCODE_OUT=16'h0005, count=1; BACKSPACE twice -> second BACKSPACE gives ERROR_PULSE, count=0.
- Strobe DIGIT_IN=4'hA -> ERROR_PULSE, count unchanged. Fill 4 digits then strobe again -> ERROR_PULSE, BARCODE_OUT unchanged.
- CLEAR and DIGIT_STROBE in the same cycle with count=2 -> count=0, no ERROR_PULSE. COMMIT with count=3 -> ERROR_PULSE, VALID stays 0.
- NUM_DIGITS=6, AUTO_COMMIT=1: strobe 9,8,7,6,5,4 -> VALID=1 the cycle after the 6th digit, BARCODE_OUT=24'h987654; a strobe during HOLD -> ERROR_PULSE.
- RESET asserted during HOLD with READY=0 -> next cycle VALID=0, count=0, mask=0, state EDIT; READY pulsed afterwards has no effect.
